mp_addsub_seq: RTL
==================

Name: mp_addsub_seq

Overview:
- Multi-cycle, multi-precision add/subtract sequencer.
- Holds one G-bit ripple-carry slice built from generate-instantiated full adders.
- Reuses that slice over N/G cycles to produce an N-bit sum or difference, with carry, borrow and overflow outputs.
- Sits between a requesting datapath and its result consumer, with valid/ready handshakes on both sides. It trades latency for area against a full N-bit ripple chain.

Parameters:
- N, 32: total operand/result width. Must be an integer multiple of G; any other value is illegal and the elaboration check fails.
- G, 8: slice width, i.e. bits processed per cycle. Must satisfy 1 <= G <= N.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- op  in  1  0 = add (a+b+cin); 1 = subtract (a+~b+cin; cin=1 gives a-b, cin=0 gives a-b-1)
- a  in  N  operand A
- b  in  N  operand B
- cin  in  1  carry-in; in subtract mode it is the inverted borrow-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  N  sum or difference
- cout  out  1  carry-out of MSB; in subtract mode, 1 = no borrow
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE; in_ready=1; out_valid=0.
  - result=0, cout=0, ovf=0.
  - Internal operand registers, carry register and chunk index cleared.
  - Reset asserted mid-RUN or mid-DONE aborts the operation immediately; no result is ever presented for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture a, b (inverted when op=1), and set carry register = cin. Clear chunk index k=0, clear result, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: slice computes a[kG+:G] + b'[kG+:G] + carry and writes result[kG+:G]. The slice carry-out goes to the carry register, then k increments.
  - On the edge where k = N/G-1: latch cout = slice carry-out and ovf = (carry into bit G-1 of the slice) XOR (slice carry-out), then go to DONE.
  - Inputs a, b, op, cin are ignored during RUN.
- DONE:
  - out_valid=1, in_ready=0.
  - result, cout and ovf are held stable until accepted.
  - On an edge with out_ready=1: go to IDLE, out_valid=0. Result, cout and ovf keep their values until the next accept.
- Latency:
  - The accepting edge is E0. out_valid is high after edge E0+N/G, i.e. N/G cycles later.
  - Minimum request-to-request spacing is N/G+2 cycles: the accept edge, N/G RUN edges, and 1 DONE edge when out_ready=1.
- No back-to-back overlap: in_ready is high only in IDLE. A new request cannot be taken on the same edge as out_valid is accepted.
- Degenerate case N=G: RUN lasts exactly one edge.
- Arithmetic is modulo 2^N. Wrap-around is reported only via cout and ovf; result is never saturated.
- Slice carry chain is purely combinational within one cycle. Only the inter-chunk carry is registered.
- in_valid and out_ready are sampled only at rising edges. in_valid held high in IDLE is consumed once per accept.

Test Plan (N=32, G=8):
1. Add, op=0, cin=0: a=0xFFFFFFFF, b=0x00000001 -> after 4 cycles out_valid=1, result=0x00000000, cout=1, ovf=0.
2. Subtract, op=1, cin=1, two requests:
   - a=5, b=3 -> result=0x00000002, cout=1, ovf=0.
   - a=3, b=5 -> result=0xFFFFFFFE, cout=0, ovf=0.
3. Overflow, op=0, cin=0: a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, cout=0, ovf=1.
   - op=1, cin=1, a=0x80000000, b=1 -> result=0x7FFFFFFF, ovf=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and different a/b driven -> result, cout and ovf unchanged and in_ready=0 throughout. Raise out_ready -> IDLE next edge. The next request is accepted only after that.
5. Reset mid-operation:
   - Assert rst_n=0 on the 2nd RUN edge -> next edge shows in_ready=1, out_valid=0, result=0.
   - Then a fresh add 0x12345678+0x11111111, cin=0 -> result=0x23456789, cout=0, ovf=0.
6. Carry propagation across chunks: a=0x00FFFFFF, b=0x00000001, op=0, cin=1 -> result=0x01000001, cout=0. Check per-chunk result bytes update in order, one per RUN cycle.

Source files
------------

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one G-bit ripple slice is reused over
// N/G cycles to build an N-bit sum or difference with carry and overflow flags.

module mp_addsub_seq_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module mp_addsub_seq #(
  parameter int N = 32,
  parameter int G = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int CHUNKS = N / G;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  generate
    if (G < 1 || G > N || (N % G) != 0) begin : g_badParams
      $error("mp_addsub_seq: N must be a positive multiple of G with 1 <= G <= N");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_result;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic            r_inReady;
  logic            r_outValid;
  logic [KW-1:0]   r_k;

  logic [G:0]      w_c;
  logic [G-1:0]    w_sum;

  // Operands shift right each RUN cycle, so the slice always reads the low G bits.
  assign w_c[0] = r_carry;

  for (genvar i = 0; i < G; i++) begin : g_slice
    mp_addsub_seq_fa u_fa (
      .i_a (r_a[i]),
      .i_b (r_b[i]),
      .i_c (w_c[i]),
      .o_s (w_sum[i]),
      .o_c (w_c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_k        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= op ? ~b : b;
            r_carry   <= cin;
            r_k       <= '0;
            r_result  <= '0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < CHUNKS; j++) begin
            if (r_k == KW'(j)) r_result[j*G +: G] <= w_sum;
          end
          r_a     <= r_a >> G;
          r_b     <= r_b >> G;
          r_carry <= w_c[G];
          r_k     <= r_k + KW'(1);
          // Overflow compares the carries into and out of the operand MSB.
          if (r_k == KW'(CHUNKS - 1)) begin
            r_cout     <= w_c[G];
            r_ovf      <= w_c[G] ^ w_c[G-1];
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
